// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter sharing a 32-word single-port RAM between
//               two requesters. Optional stats counters: RAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d_in,
    input  logic [DW-1:0] ram_d_out,
    output logic          busy
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]   m0_grants,
    output logic [15:0]   m1_grants,
    output logic [15:0]   err_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_depth = AW'(DEPTH);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic          r_winner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic          w_sample;
    logic          w_grant;
    logic          w_pick;
    logic          w_in_range;

    assign w_sample   = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_grant    = w_sample && (m0_req || m1_req);
    // On a tie the requester that did not win last time goes first.
    assign w_pick     = (m0_req && m1_req) ? ~r_last_grant : m1_req;
    assign w_in_range = (r_addr < c_depth);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = w_grant ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = w_grant ? S_ACCESS : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_d_in  = '0;
        busy      = 1'b0;
        case (r_state)
            S_ACCESS: begin
                busy     = 1'b1;
                m0_gnt   = ~r_winner;
                m1_gnt   = r_winner;
                ram_addr = w_in_range ? r_addr : '0;
                ram_d_in = r_wdata;
                // Reset kills an in-flight write in the same cycle.
                ram_we   = r_we && w_in_range && !rst;
            end
            S_RESP: begin
                busy = 1'b1;
                if (r_winner) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = r_rdata;
                    m1_err    = r_err;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = r_rdata;
                    m0_err    = r_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_winner     <= w_pick;
                r_last_grant <= w_pick;
                r_we         <= w_pick ? m1_we    : m0_we;
                r_addr       <= w_pick ? m1_addr  : m0_addr;
                r_wdata      <= w_pick ? m1_wdata : m0_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= (!r_we && w_in_range) ? ram_d_out : '0;
                r_err   <= !w_in_range;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [AW-1:0] w_pick_addr;
    assign w_pick_addr = w_pick ? m1_addr : m0_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_grants <= '0;
            m1_grants <= '0;
            err_count <= '0;
        end else if (w_grant) begin
            if (!w_pick && m0_grants != 16'hFFFF) m0_grants <= m0_grants + 16'd1;
            if (w_pick && m1_grants != 16'hFFFF)  m1_grants <= m1_grants + 16'd1;
            if (!(w_pick_addr < c_depth) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter sharing the single-port data RAM (sync write, async read, 32 words) between requester 0 (CPU data port) and requester 1 (debug loader / DMA).
- Sits between the requesters and the RAM's we/addr/d_in/d_out pins.
- Serialises accesses with round-robin fairness and per-requester req/gnt/rvalid handshakes.
- Rejects out-of-range addresses without touching memory.

Parameters:
AW, 32, address width of requester and RAM address ports
DW, 32, data width
DEPTH, 32, number of valid RAM words; addresses >= DEPTH are errors

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
m0_req  input  1  requester 0 access request; hold with we/addr/wdata stable until m0_gnt
m0_we  input  1  requester 0: 1 = write, 0 = read
m0_addr  input  AW  requester 0 word address
m0_wdata  input  DW  requester 0 write data
m0_gnt  output  1  requester 0 access cycle in progress
m0_rvalid  output  1  requester 0 response valid (reads and writes)
m0_rdata  output  DW  requester 0 read data, valid with m0_rvalid
m0_err  output  1  requester 0 address out of range, valid with m0_rvalid
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_* for requester 1
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_d_in  output  DW  RAM write data
ram_d_out  input  DW  RAM async read data
busy  output  1  high in ACCESS and RESP

Behaviour:
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- Request sampling happens only on edges ending IDLE or RESP.
- Sampling edge with any req high: pick winner, latch its we/addr/wdata, go to ACCESS. Otherwise go or stay in IDLE.
- Round robin: 1-bit last_grant, reset value 1, so m0 wins the first tie.
  - Both requesting: winner is the one != last_grant.
  - Single request: that requester wins.
  - last_grant updates to the winner on each grant.
- ACCESS (1 cycle):
  - Winner's gnt = 1.
  - ram_addr = latched addr if in range (addr < DEPTH), else 0.
  - ram_d_in = latched wdata.
  - ram_we = latched we & in_range & !rst.
  - On the edge ending ACCESS: rdata_reg <= ram_d_out if (read & in_range), else 0; err_reg <= !in_range. Go to RESP.
- RESP (1 cycle):
  - Winner's rvalid = 1, with rdata/err from registers.
  - Writes also get rvalid (rdata = 0).
  - Sampling edge: goes to ACCESS if any req is high, else IDLE.
- Latency: req sampled at edge T → gnt during cycle T+1 → rvalid during cycle T+2.
  - Peak throughput: one access per 2 cycles.
- Requester rule: deassert req no later than the edge ending its gnt cycle. Req still high at the RESP sampling edge is treated as a new request.
- Read-after-write, same address: the write commits at the edge ending ACCESS, so a later access reads the new value.
- Out of range: no write; rvalid with err = 1 and rdata = 0.
- Idle outputs: ram_we = 0, ram_addr = 0, ram_d_in = 0; all gnt/rvalid/err = 0; rdata outputs 0 when rvalid = 0.
- rst asserted in any state:
  - ram_we forced 0 combinationally in that cycle, so an in-flight write is dropped.
  - Next cycle: IDLE, last_grant = 1, all registers cleared, no rvalid issued.

Optional Feature:
RAM_ARB_STATS_EN
- Defined: adds outputs m0_grants [15:0], m1_grants [15:0], err_count [15:0].
  - Each is a saturating counter (sticks at 0xFFFF).
  - Grant counters increment on entry to ACCESS for the respective requester.
  - err_count increments on entry to ACCESS with an out-of-range address.
  - All cleared by rst.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
1. Reset → all outputs 0. m0 write addr 8 data 0x000000A5 → ram_we = 1 for exactly one cycle (gnt cycle) with ram_addr = 8; m0_rvalid next cycle, err = 0. Then m0 read addr 8 → m0_rdata = 0x000000A5.
2. m0_req and m1_req asserted on the same edge, both held → grants alternate m0, m1, m0, m1 every 2 cycles. No gnt overlap; rvalid only to the matching requester.
3. m1 write addr 32 (DEPTH = 32) → ram_we stays 0, m1_err = 1, m1_rdata = 0. Reading addr 31 afterwards returns its prior value, unchanged.
4. m0 issues 4 back-to-back reads (addr 0..3, req re-asserted after each gnt) → rvalid every 2nd cycle, data matches RAM contents, busy held high throughout.
5. rst pulsed during an ACCESS write (m0 addr 5, data 0x12345678) → ram_we = 0 in that cycle, addr 5 unchanged, no m0_rvalid. Next tie after reset is won by m0.
6. With RAM_ARB_STATS_EN defined: 3 m0 grants, 2 m1 grants (1 out-of-range) → m0_grants = 3, m1_grants = 2, err_count = 1. After rst, all counters are 0.
